fifo_burst_reader: RTL and testbench

- Read-side master for the team's 8-entry FIFO (fifo_cal_addr and its state machine, states INIT/READ/WRITE/RD_ERROR/WR_ERROR/NO_OP).
- On a start pulse it drains a programmed number of words from the FIFO using the FIFO's rd_en/rd_ack/rd_err handshake.
- It re-presents those words on a valid/ready output stream, through a 2-entry output buffer, so that downstream backpressure never loses data.

---
 rtl/fifo_defs.sv | 28 ++
 rtl/fifo_burst_reader_if.sv | 42 ++++
 rtl/fifo_out_buf.sv | 68 ++++++
 rtl/fifo_burst_reader.sv | 136 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_defs.sv
// Shared definitions for the 8-entry FIFO and its burst read master:
// FIFO state encodings, reader FSM states and depth constants.
package fifo_defs;

    localparam int FIFO_DEPTH    = 8;
    localparam int OUT_BUF_DEPTH = 2;

    typedef enum logic [2:0] {
        FIFO_INIT     = 3'b000,
        FIFO_READ     = 3'b001,
        FIFO_WRITE    = 3'b010,
        FIFO_RD_ERROR = 3'b011,
        FIFO_WR_ERROR = 3'b100,
        FIFO_NO_OP    = 3'b101
    } fifo_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_RUN   = 2'b01,
        RD_FLUSH = 2'b10,
        RD_DONE  = 2'b11
    } reader_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read handshake plus valid/ready output stream of the burst reader.
// master = the reader, slave = FIFO/downstream side.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_ack;
    logic                  fifo_rd_err;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  fifo_data_count;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_rd_ack,
        input  fifo_rd_err,
        input  fifo_empty,
        input  fifo_data_count,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_rd_ack,
        output fifo_rd_err,
        output fifo_empty,
        output fifo_data_count,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry first-in first-out skid buffer between the FIFO read port
// and the output stream; head entry is always presented.
module fifo_out_buf
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] mem_q [OUT_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [OUT_BUF_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (occ_q == 2'(OUT_BUF_DEPTH));
    assign do_pop    = pop && (occ_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the 8-entry FIFO: drains burst_len words on start
// and re-presents them on a valid/ready stream without losing data.
module fifo_burst_reader
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] burst_len,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           err_cnt,
    fifo_burst_reader_if.master  bus
);

    reader_state_t         state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [1:0]            inflight_q, inflight_d;
    logic                  rd_en_q, rd_en_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  issue;
    logic                  resp_ack;
    logic                  resp_err;
    logic                  resp_any;
    logic                  buf_pop;
    logic [2:0]            credits_used;
    logic [1:0]            occupancy;
    logic [DATA_WIDTH-1:0] head_data;

    // Responses are only honoured while a read is outstanding, so stray acks after reset are dropped.
    assign resp_err = bus.fifo_rd_err && (inflight_q != 2'd0);
    assign resp_ack = bus.fifo_rd_ack && !bus.fifo_rd_err && (inflight_q != 2'd0);
    assign resp_any = resp_ack || resp_err;
    assign buf_pop  = (occupancy != 2'd0) && bus.m_ready;

    assign credits_used = {1'b0, occupancy} + {1'b0, inflight_q} - {2'b00, buf_pop};

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_ack),
        .push_data (bus.fifo_dout),
        .pop       (buf_pop),
        .head_data (head_data),
        .occupancy (occupancy)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        inflight_d  = inflight_q;
        err_cnt_d   = err_cnt_q;
        issue       = 1'b0;

        if (state_q == RD_RUN && remaining_q != '0 && !bus.fifo_empty &&
            bus.fifo_data_count != CNT_WIDTH'(0) && credits_used < 3'd2) begin
            issue = 1'b1;
        end

        if (resp_err) begin
            err_cnt_d = sat_inc8(err_cnt_q);
        end

        // A failed read hands its word back to the burst so it is retried.
        case ({issue, resp_err})
            2'b10:   remaining_d = remaining_q - LEN_WIDTH'(1);
            2'b01:   remaining_d = remaining_q + LEN_WIDTH'(1);
            default: remaining_d = remaining_q;
        endcase

        case ({issue, resp_any})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        // Exit decisions use next-cycle values so done lands right after the last transfer.
        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    state_d     = (burst_len == '0) ? RD_DONE : RD_RUN;
                end
            end
            RD_RUN: begin
                if (remaining_d == '0 && inflight_d == 2'd0) begin
                    state_d = RD_FLUSH;
                end
            end
            RD_FLUSH: begin
                if (occupancy == 2'd0 || (occupancy == 2'd1 && buf_pop)) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        rd_en_d = issue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RD_IDLE;
            remaining_q <= '0;
            inflight_q  <= 2'd0;
            rd_en_q     <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            rd_en_q     <= rd_en_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy           = (state_q != RD_IDLE);
    assign done           = (state_q == RD_DONE);
    assign err_cnt        = err_cnt_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.m_valid    = (occupancy != 2'd0);
    assign bus.m_data     = head_data;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 8-entry FIFO
// responding on the rd_en/rd_ack/rd_err handshake.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic [7:0]    err_cnt;
    logic          m_ready_drv;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_if ();

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: a read on empty or on the armed read index answers with rd_err.
    logic [DW-1:0] fifo_mem [8];
    int            fifo_count = 0;
    int            fifo_head = 0;
    int            read_idx = 0;
    int            err_at_read = -1;
    logic          model_ack, model_err;
    logic [DW-1:0] model_dout;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          late_ack = 1'b0;
    logic [DW-1:0] late_dout = '0;

    always @(posedge clk or posedge reset) begin : fifo_model
        int cnt;
        if (reset) begin
            fifo_count <= 0;
            fifo_head  <= 0;
            model_ack  <= 1'b0;
            model_err  <= 1'b0;
            model_dout <= '0;
        end else begin
            cnt = fifo_count;
            model_ack <= 1'b0;
            model_err <= 1'b0;
            if (bus_if.fifo_rd_en) begin
                if (read_idx == err_at_read || fifo_count == 0) begin
                    model_err <= 1'b1;
                end else begin
                    model_ack  <= 1'b1;
                    model_dout <= fifo_mem[fifo_head];
                    fifo_head  <= (fifo_head + 1) % 8;
                    cnt = cnt - 1;
                end
                read_idx <= read_idx + 1;
            end
            if (wr_req && fifo_count < 8) begin
                fifo_mem[(fifo_head + fifo_count) % 8] <= wr_data;
                cnt = cnt + 1;
            end
            fifo_count <= cnt;
        end
    end

    assign bus_if.fifo_rd_ack     = model_ack | late_ack;
    assign bus_if.fifo_rd_err     = model_err;
    assign bus_if.fifo_dout       = late_ack ? late_dout : model_dout;
    assign bus_if.fifo_empty      = (fifo_count == 0);
    assign bus_if.fifo_data_count = CW'(fifo_count);
    assign bus_if.m_ready         = m_ready_drv;

    int            cycle_cnt = 0;
    int            rd_en_total = 0;
    int            done_total = 0;
    int            xfer_total = 0;
    int            last_xfer_cycle = 0;
    int            last_done_cycle = 0;
    int            overflow_total = 0;
    logic [DW-1:0] xfer_log [256];

    always @(posedge clk) cycle_cnt++;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.fifo_rd_en) rd_en_total++;
            if (done) begin
                done_total++;
                last_done_cycle = cycle_cnt;
            end
            if (bus_if.m_valid && bus_if.m_ready) begin
                xfer_log[xfer_total % 256] = bus_if.m_data;
                xfer_total++;
                last_xfer_cycle = cycle_cnt;
            end
            if (dut.u_buf.push && dut.u_buf.occupancy == 2'd2 && !dut.u_buf.pop) overflow_total++;
        end
    end

    int check_total = 0;
    int pass_total = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_total++;
        if (observed === expected) pass_total++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [LW-1:0] len);
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic write_fifo(input logic [DW-1:0] data);
        wr_data = data;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < max_cycles && seen == 0; i++) begin
            tick();
            if (done) seen = 1;
        end
        checkOutput(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < max_cycles && seen == 0; i++) begin
            tick();
            if (bus_if.m_valid) seen = 1;
        end
        checkOutput(tag, 64'(seen), 64'd1);
    endtask

    int            base_rd, base_x, base_d;
    logic [DW-1:0] exp_words [5];

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        burst_len   = '0;
        m_ready_drv = 1'b1;
        repeat (3) tick();

        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_rd_en", 64'(bus_if.fifo_rd_en), 64'd0);
        checkOutput("reset_m_valid", 64'(bus_if.m_valid), 64'd0);
        checkOutput("reset_m_data", 64'(bus_if.m_data), 64'd0);
        checkOutput("reset_err_cnt", 64'(err_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // Five preloaded words streamed with m_ready held high.
        exp_words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        for (int i = 0; i < 5; i++) write_fifo(exp_words[i]);
        base_rd = rd_en_total; base_x = xfer_total; base_d = done_total;
        applyStimulus(8'd5);
        wait_done("t2_done_seen", 40);
        checkOutput("t2_busy_during_done", 64'(busy), 64'd1);
        tick();
        checkOutput("t2_busy_falls", 64'(busy), 64'd0);
        checkOutput("t2_done_one_cycle", 64'(done), 64'd0);
        checkOutput("t2_rd_en_count", 64'(rd_en_total - base_rd), 64'd5);
        checkOutput("t2_xfer_count", 64'(xfer_total - base_x), 64'd5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("t2_data%0d", i), 64'(xfer_log[base_x + i]), 64'(exp_words[i]));
        checkOutput("t2_done_count", 64'(done_total - base_d), 64'd1);
        checkOutput("t2_done_after_last_xfer", 64'(last_done_cycle - last_xfer_cycle), 64'd1);

        // Backpressure: only two words may be fetched while the stream is stalled.
        m_ready_drv = 1'b0;
        write_fifo(32'h31); write_fifo(32'h32); write_fifo(32'h33);
        base_rd = rd_en_total; base_x = xfer_total; base_d = done_total;
        applyStimulus(8'd3);
        repeat (4) tick();
        checkOutput("t3_head_early", 64'(bus_if.m_data), 64'h31);
        repeat (6) tick();
        checkOutput("t3_reads_blocked", 64'(rd_en_total - base_rd), 64'd2);
        checkOutput("t3_m_valid", 64'(bus_if.m_valid), 64'd1);
        checkOutput("t3_head_stable", 64'(bus_if.m_data), 64'h31);
        checkOutput("t3_occupancy", 64'(dut.u_buf.occupancy), 64'd2);
        checkOutput("t3_no_xfer_blocked", 64'(xfer_total - base_x), 64'd0);
        m_ready_drv = 1'b1;
        wait_done("t3_done_seen", 30);
        tick();
        checkOutput("t3_rd_en_count", 64'(rd_en_total - base_rd), 64'd3);
        checkOutput("t3_xfer_count", 64'(xfer_total - base_x), 64'd3);
        checkOutput("t3_data0", 64'(xfer_log[base_x]), 64'h31);
        checkOutput("t3_data1", 64'(xfer_log[base_x + 1]), 64'h32);
        checkOutput("t3_data2", 64'(xfer_log[base_x + 2]), 64'h33);
        checkOutput("t3_done_count", 64'(done_total - base_d), 64'd1);

        // Empty FIFO: the reader waits, then drains words written later.
        base_rd = rd_en_total; base_x = xfer_total; base_d = done_total;
        applyStimulus(8'd2);
        repeat (6) tick();
        checkOutput("t4_no_read_empty", 64'(rd_en_total - base_rd), 64'd0);
        checkOutput("t4_busy_waiting", 64'(busy), 64'd1);
        write_fifo(32'h41);
        write_fifo(32'h42);
        wait_done("t4_done_seen", 30);
        tick();
        checkOutput("t4_rd_en_count", 64'(rd_en_total - base_rd), 64'd2);
        checkOutput("t4_data0", 64'(xfer_log[base_x]), 64'h41);
        checkOutput("t4_data1", 64'(xfer_log[base_x + 1]), 64'h42);
        checkOutput("t4_done_count", 64'(done_total - base_d), 64'd1);
        checkOutput("t4_err_cnt", 64'(err_cnt), 64'd0);

        // One read answered with rd_err is retried.
        write_fifo(32'hA1);
        write_fifo(32'hA2);
        base_rd = rd_en_total; base_x = xfer_total; base_d = done_total;
        err_at_read = read_idx;
        applyStimulus(8'd2);
        wait_done("t5_done_seen", 40);
        tick();
        err_at_read = -1;
        checkOutput("t5_err_cnt", 64'(err_cnt), 64'd1);
        checkOutput("t5_rd_en_count", 64'(rd_en_total - base_rd), 64'd3);
        checkOutput("t5_xfer_count", 64'(xfer_total - base_x), 64'd2);
        checkOutput("t5_data0", 64'(xfer_log[base_x]), 64'hA1);
        checkOutput("t5_data1", 64'(xfer_log[base_x + 1]), 64'hA2);
        checkOutput("t5_done_count", 64'(done_total - base_d), 64'd1);

        // Zero-length burst, plus a start during busy that must be ignored.
        base_rd = rd_en_total; base_d = done_total;
        checkOutput("t6_done_low_before", 64'(done), 64'd0);
        applyStimulus(8'd0);
        checkOutput("t6_done_pulse", 64'(done), 64'd1);
        checkOutput("t6_busy_in_done", 64'(busy), 64'd1);
        applyStimulus(8'd4);
        checkOutput("t6_done_cleared", 64'(done), 64'd0);
        checkOutput("t6_idle_after_done", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("t6_second_start_ignored", 64'(busy), 64'd0);
        checkOutput("t6_no_reads", 64'(rd_en_total - base_rd), 64'd0);
        checkOutput("t6_done_count", 64'(done_total - base_d), 64'd1);

        // Reset in the middle of a burst with one word buffered.
        m_ready_drv = 1'b0;
        write_fifo(32'h61); write_fifo(32'h62); write_fifo(32'h63);
        applyStimulus(8'd3);
        wait_valid("t7_word_buffered", 10);
        checkOutput("t7_occupancy_before", 64'(dut.u_buf.occupancy), 64'd1);
        reset = 1'b1;
        tick();
        checkOutput("t7_m_valid", 64'(bus_if.m_valid), 64'd0);
        checkOutput("t7_busy", 64'(busy), 64'd0);
        checkOutput("t7_rd_en", 64'(bus_if.fifo_rd_en), 64'd0);
        checkOutput("t7_err_cnt", 64'(err_cnt), 64'd0);
        reset     = 1'b0;
        late_dout = 32'hDEAD;
        late_ack  = 1'b1;
        tick();
        late_ack  = 1'b0;
        tick();
        checkOutput("t7_late_ack_ignored", 64'(bus_if.m_valid), 64'd0);
        checkOutput("t7_still_idle", 64'(busy), 64'd0);

        checkOutput("no_push_into_full", 64'(overflow_total), 64'd0);
        $display("%0d/%0d checks passed", pass_total, check_total);
        $finish;
    end

endmodule
